// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single data memory port.
// One outstanding transaction; bad requests are answered without a memory access.
module dmem_arbiter #(
  parameter int DROM_SPACE = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req_valid,
  output logic        p0_req_ready,
  input  logic        p0_req_we,
  input  logic [31:0] p0_req_addr,
  input  logic [31:0] p0_req_wdata,
  input  logic [1:0]  p0_req_size,
  output logic        p0_rsp_valid,
  input  logic        p0_rsp_ready,
  output logic [31:0] p0_rsp_rdata,
  output logic        p0_rsp_err,
  input  logic        p1_req_valid,
  output logic        p1_req_ready,
  input  logic        p1_req_we,
  input  logic [31:0] p1_req_addr,
  input  logic [31:0] p1_req_wdata,
  input  logic [1:0]  p1_req_size,
  output logic        p1_rsp_valid,
  input  logic        p1_rsp_ready,
  output logic [31:0] p1_rsp_rdata,
  output logic        p1_rsp_err,
  output logic [31:0] data_addr,
  output logic [31:0] w_data_mem,
  output logic        r_en_mem,
  output logic        w_en_mem,
  output logic [1:0]  byte_sel,
  input  logic [31:0] r_data_mem
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t      r_state;
  logic        r_gnt;
  logic        r_last;
  logic        r_we;
  logic        r_err;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [1:0]  r_size;

  logic        w_any;
  logic        w_sel;
  logic        w_we;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic [1:0]  w_size;
  logic [32:0] w_bytes;
  logic [32:0] w_end;
  logic        w_err;
  logic [31:0] w_load;
  logic        w_rsp_rdy;
  logic        w_access;
  logic        w_resp;
  logic        w_idle;

  assign w_any = p0_req_valid | p1_req_valid;
  // On a tie the port that was not served last wins
  assign w_sel = (p0_req_valid & p1_req_valid) ? ~r_last : p1_req_valid;

  assign w_we    = w_sel ? p1_req_we    : p0_req_we;
  assign w_addr  = w_sel ? p1_req_addr  : p0_req_addr;
  assign w_wdata = w_sel ? p1_req_wdata : p0_req_wdata;
  assign w_size  = w_sel ? p1_req_size  : p0_req_size;

  always_comb begin
    w_bytes = 33'd4;
    unique case (w_size)
      2'b00:   w_bytes = 33'd1;
      2'b01:   w_bytes = 33'd2;
      default: w_bytes = 33'd4;
    endcase
  end

  assign w_end = {1'b0, w_addr} + w_bytes;
  assign w_err = (w_size == 2'b11)
               | ((w_size == 2'b01) & w_addr[0])
               | ((w_size == 2'b10) & (|w_addr[1:0]))
               | (w_end > 33'(DROM_SPACE));

  always_comb begin
    w_load = r_data_mem;
    unique case (r_size)
      2'b00:   w_load = {24'd0, r_data_mem[7:0]};
      2'b01:   w_load = {16'd0, r_data_mem[15:0]};
      default: w_load = r_data_mem;
    endcase
  end

  assign w_rsp_rdy = r_gnt ? p1_rsp_ready : p0_rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_gnt   <= 1'b0;
      r_last  <= 1'b1;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_size  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt   <= w_sel;
            r_we    <= w_we;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_size  <= w_size;
            r_err   <= w_err;
            r_rdata <= '0;
            r_state <= w_err ? S_RESP : S_ACCESS;
          end
        end
        S_ACCESS: begin
          r_rdata <= r_we ? 32'd0 : w_load;
          r_state <= S_RESP;
        end
        S_RESP: begin
          if (w_rsp_rdy) begin
            r_last  <= r_gnt;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Every output is forced low while reset is held
  assign w_idle   = ~rst & (r_state == S_IDLE);
  assign w_access = ~rst & (r_state == S_ACCESS);
  assign w_resp   = ~rst & (r_state == S_RESP);

  assign p0_req_ready = w_idle & w_any & ~w_sel;
  assign p1_req_ready = w_idle & w_any & w_sel;

  assign data_addr  = w_access ? r_addr  : 32'd0;
  assign w_data_mem = w_access ? r_wdata : 32'd0;
  assign byte_sel   = w_access ? r_size  : 2'b00;
  assign r_en_mem   = w_access & ~r_we;
  assign w_en_mem   = w_access & r_we;

  assign p0_rsp_valid = w_resp & ~r_gnt;
  assign p1_rsp_valid = w_resp & r_gnt;
  assign p0_rsp_rdata = p0_rsp_valid ? r_rdata : 32'd0;
  assign p1_rsp_rdata = p1_rsp_valid ? r_rdata : 32'd0;
  assign p0_rsp_err   = p0_rsp_valid & r_err;
  assign p1_rsp_err   = p1_rsp_valid & r_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a byte-addressed memory model.
// Directed requests push expectations; a monitor pops them on each response.
module tb_dmem_arbiter;
  localparam int DS = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic p0_req_valid = 0, p0_req_we = 0, p0_rsp_ready = 1;
  logic p1_req_valid = 0, p1_req_we = 0, p1_rsp_ready = 1;
  logic [31:0] p0_req_addr = 0, p0_req_wdata = 0;
  logic [31:0] p1_req_addr = 0, p1_req_wdata = 0;
  logic [1:0] p0_req_size = 0, p1_req_size = 0;
  logic p0_req_ready, p1_req_ready;
  logic p0_rsp_valid, p1_rsp_valid, p0_rsp_err, p1_rsp_err;
  logic [31:0] p0_rsp_rdata, p1_rsp_rdata;
  logic [31:0] data_addr, w_data_mem, r_data_mem;
  logic r_en_mem, w_en_mem;
  logic [1:0] byte_sel;

  dmem_arbiter #(.DROM_SPACE(DS)) dut (
    .clk(clk), .rst(rst),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready),
    .p0_req_we(p0_req_we), .p0_req_addr(p0_req_addr),
    .p0_req_wdata(p0_req_wdata), .p0_req_size(p0_req_size),
    .p0_rsp_valid(p0_rsp_valid), .p0_rsp_ready(p0_rsp_ready),
    .p0_rsp_rdata(p0_rsp_rdata), .p0_rsp_err(p0_rsp_err),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready),
    .p1_req_we(p1_req_we), .p1_req_addr(p1_req_addr),
    .p1_req_wdata(p1_req_wdata), .p1_req_size(p1_req_size),
    .p1_rsp_valid(p1_rsp_valid), .p1_rsp_ready(p1_rsp_ready),
    .p1_rsp_rdata(p1_rsp_rdata), .p1_rsp_err(p1_rsp_err),
    .data_addr(data_addr), .w_data_mem(w_data_mem),
    .r_en_mem(r_en_mem), .w_en_mem(w_en_mem),
    .byte_sel(byte_sel), .r_data_mem(r_data_mem)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: mem[i] starts as i[7:0]; reads are LSB-aligned at data_addr
  logic [7:0] mem [0:DS-1];
  logic [9:0] ma;
  assign ma = data_addr[9:0];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DS; i++) mem[i] <= 8'(i);
    end else if (w_en_mem) begin
      mem[ma] <= w_data_mem[7:0];
      if (byte_sel != 2'b00) mem[ma + 10'd1] <= w_data_mem[15:8];
      if (byte_sel == 2'b10) begin
        mem[ma + 10'd2] <= w_data_mem[23:16];
        mem[ma + 10'd3] <= w_data_mem[31:24];
      end
    end
  end

  always_comb begin
    r_data_mem = 32'd0;
    if (data_addr < 32'(DS - 3))
      r_data_mem = {mem[ma + 10'd3], mem[ma + 10'd2],
                    mem[ma + 10'd1], mem[ma]};
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int glog[$];
  int n_tests = 0;
  int n_fail = 0;
  int n_ren = 0;
  int n_wen = 0;
  logic [1:0] wsel = 0;
  logic prv0 = 0, prv1 = 0;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endfunction

  function automatic logic [31:0] outs_or();
    return p0_rsp_rdata | p1_rsp_rdata | data_addr | w_data_mem |
           32'({p0_req_ready, p1_req_ready, p0_rsp_valid,
                p1_rsp_valid, p0_rsp_err, p1_rsp_err,
                r_en_mem, w_en_mem, byte_sel});
  endfunction

  // Monitor: samples 2 time units after each falling edge
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (!rst) begin
      if (p0_req_ready) glog.push_back(0);
      if (p1_req_ready) glog.push_back(1);
      if (r_en_mem) n_ren++;
      if (w_en_mem) begin
        n_wen++;
        wsel = byte_sel;
      end
      if (r_en_mem | w_en_mem)
        chk("en_exclusive", 32'(r_en_mem & w_en_mem), 0);
      else
        chk("mem_idle_zero", data_addr | w_data_mem | 32'(byte_sel), 0);
      if (p0_rsp_valid) begin
        chk("p1_rsp_quiet", p1_rsp_rdata | 32'({p1_rsp_valid, p1_rsp_err}), 0);
        if (!prv0) begin
          chk("p0_rsp_expected", 32'(q0.size() != 0), 1);
          if (q0.size() != 0) chk("p0_latency", 32'(cyc), 32'(q0[0].due));
        end
        if (p0_rsp_ready && q0.size() != 0) begin
          e = q0.pop_front();
          chk("p0_rdata", p0_rsp_rdata, e.rdata);
          chk("p0_err", 32'(p0_rsp_err), 32'(e.err));
        end
      end
      if (p1_rsp_valid) begin
        chk("p0_rsp_quiet", p0_rsp_rdata | 32'({p0_rsp_valid, p0_rsp_err}), 0);
        if (!prv1) begin
          chk("p1_rsp_expected", 32'(q1.size() != 0), 1);
          if (q1.size() != 0) chk("p1_latency", 32'(cyc), 32'(q1[0].due));
        end
        if (p1_rsp_ready && q1.size() != 0) begin
          e = q1.pop_front();
          chk("p1_rdata", p1_rsp_rdata, e.rdata);
          chk("p1_err", 32'(p1_rsp_err), 32'(e.err));
        end
      end
    end
    prv0 = p0_rsp_valid;
    prv1 = p1_rsp_valid;
  end

  task automatic drive(input int p, input logic v, input logic we,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] sz);
    if (p == 0) begin
      p0_req_valid = v; p0_req_we = we; p0_req_addr = a;
      p0_req_wdata = wd; p0_req_size = sz;
    end else begin
      p1_req_valid = v; p1_req_we = we; p1_req_addr = a;
      p1_req_wdata = wd; p1_req_size = sz;
    end
  endtask

  task automatic req(input int p, input logic we, input logic [31:0] a,
                     input logic [31:0] wd, input logic [1:0] sz,
                     input logic [31:0] er, input logic ee);
    int n = 0;
    bit ok = 0;
    exp_t e;
    @(negedge clk);
    drive(p, 1'b1, we, a, wd, sz);
    while (!ok && n < 60) begin
      #1;
      if ((p == 0) ? p0_req_ready : p1_req_ready) ok = 1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    chk("accept_in_time", 32'(ok), 1);
    if (ok) begin
      e.rdata = er;
      e.err = ee;
      e.due = cyc + (ee ? 1 : 2);
      if (p == 0) q0.push_back(e);
      else q1.push_back(e);
    end
    @(posedge clk);
    #1;
    drive(p, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00);
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() + q1.size()) != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(q0.size() + q1.size()), 0);
    @(negedge clk);
  endtask

  task automatic chk_glog(input int a, input int b, input int c,
                          input int d, input int len);
    int ex[4];
    ex = '{a, b, c, d};
    chk("grant_count", 32'(glog.size()), 32'(len));
    for (int i = 0; i < len && i < glog.size(); i++)
      chk("grant_order", 32'(glog[i]), 32'(ex[i]));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1);
  end

  initial begin
    int n;
    bit p1_done;
    // Reset: outputs low even with a request pending
    p0_req_valid = 1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", outs_or(), 0);
    p0_req_valid = 0;
    @(negedge clk);
    rst = 0;
    #1;
    chk("idle_outputs", outs_or(), 0);

    // Round-robin with both ports continuously requesting loads
    glog.delete();
    fork
      begin
        req(0, 0, 32'h20, 0, 2'b10, 32'h23222120, 0);
        req(0, 0, 32'h40, 0, 2'b01, 32'h00004140, 0);
      end
      begin
        req(1, 0, 32'h30, 0, 2'b10, 32'h33323130, 0);
        req(1, 0, 32'h55, 0, 2'b00, 32'h00000055, 0);
      end
    join
    drain();
    chk_glog(0, 1, 0, 1, 4);

    // Word store then word load
    n_wen = 0;
    req(0, 1, 32'h10, 32'hDEADBEEF, 2'b10, 32'h0, 0);
    drain();
    chk("store_wen_cycles", 32'(n_wen), 1);
    chk("store_byte_sel", 32'(wsel), 32'h2);
    req(0, 0, 32'h10, 0, 2'b10, 32'hDEADBEEF, 0);
    drain();

    // Misaligned half and out-of-range word
    n_ren = 0;
    n_wen = 0;
    req(1, 0, 32'h3, 0, 2'b01, 32'h0, 1);
    req(1, 0, 32'(DS - 2), 0, 2'b10, 32'h0, 1);
    req(1, 0, 32'(DS - 4), 0, 2'b11, 32'h0, 1);
    drain();
    chk("err_no_mem_enable", 32'(n_ren + n_wen), 0);

    // Stalled response on port 0 while port 1 waits
    p0_rsp_ready = 0;
    p1_done = 0;
    req(0, 0, 32'h20, 0, 2'b10, 32'h23222120, 0);
    fork
      begin
        req(1, 0, 32'h30, 0, 2'b10, 32'h33323130, 0);
        p1_done = 1;
      end
    join_none
    n = 0;
    while (!p0_rsp_valid && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(p0_rsp_valid), 1);
      chk("stall_rdata", p0_rsp_rdata, 32'h23222120);
      chk("stall_p1_ready", 32'(p1_req_ready), 0);
      @(negedge clk);
      #1;
    end
    p0_rsp_ready = 1;
    @(negedge clk);
    #1;
    chk("p1_grant_after_hs", 32'(p1_req_ready), 1);
    n = 0;
    while (!p1_done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("p1_done", 32'(p1_done), 1);
    drain();

    // Byte load from the stored word
    req(0, 0, 32'h11, 0, 2'b00, 32'h000000BE, 0);
    drain();

    // Reset while in ACCESS aborts the transaction
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'h20, 32'h0, 2'b10);
    #1;
    chk("abort_accept", 32'(p0_req_ready), 1);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
    @(negedge clk);
    #1;
    chk("abort_in_access", 32'(r_en_mem), 1);
    rst = 1;
    #1;
    chk("abort_rst_outputs", outs_or(), 0);
    @(negedge clk);
    #1;
    chk("abort_next_outputs", outs_or(), 0);
    rst = 0;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("abort_no_rsp", 32'({p0_rsp_valid, p1_rsp_valid, r_en_mem}), 0);
    end
    glog.delete();
    fork
      req(0, 0, 32'h24, 0, 2'b10, 32'h27262524, 0);
      req(1, 0, 32'h34, 0, 2'b10, 32'h37363534, 0);
    join
    drain();
    chk_glog(0, 1, 0, 0, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
